// File: rtl/tpu_pkg.sv
// Shared types for the systolic array control path: PE arithmetic modes
// and the tile sequencer state encoding.
package tpu_pkg;

    typedef enum logic [1:0] {
        MODE_Q88    = 2'b00,
        MODE_INT16  = 2'b01,
        MODE_INT8X2 = 2'b10,
        MODE_INT4X4 = 2'b11
    } sys_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD0,
        ST_STREAM,
        ST_WAIT,
        ST_DRAIN,
        ST_FIN
    } seq_state_e;

endpackage

// File: rtl/skew_shift.sv
// N-tap delay line: tap k carries the input delayed by k cycles, tap 0 is
// the input itself. Used to build diagonal row skew and column stagger.
module skew_shift #(
    parameter int W = 1,
    parameter int N = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W-1:0]          d_i,
    output logic [N-1:0][W-1:0]   taps_o
);

    logic [N-1:1][W-1:0] stage_q;

    // Shift the input one stage further down the line every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[1] <= d_i;
            for (int k = 2; k < N; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
        end
    end

    // Expose the undelayed input as tap 0 and the registered stages after it.
    always_comb begin
        taps_o[0] = d_i;
        for (int k = 1; k < N; k++) begin
            taps_o[k] = stage_q[k];
        end
    end

endmodule

// File: rtl/systolic_array_sequencer.sv
// Tile sequencer for an NxN weight-stationary systolic array. Loads weight
// rows bottom-first, streams skewed activation vectors, prefetches the next
// tile's weights behind the current stream, and flags psum-valid columns.
module systolic_array_sequencer
    import tpu_pkg::*;
#(
    parameter int N   = 4,
    parameter int M_W = 16,
    parameter int T_W = 8,
    parameter int AW  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [1:0]         cfg_mode_i,
    input  logic [M_W-1:0]     cfg_m_i,
    input  logic [T_W-1:0]     cfg_tiles_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [1:0]         sys_mode_o,
    output logic               arr_enabled_o,
    output logic               wbuf_rd_en_o,
    output logic [AW-1:0]      wbuf_rd_addr_o,
    output logic [N-1:0]       arr_accept_w_o,
    output logic [N-1:0]       abuf_rd_en_o,
    output logic [N*AW-1:0]    abuf_rd_addr_o,
    output logic [N-1:0]       arr_valid_o,
    output logic [N-1:0]       arr_switch_o,
    output logic [N-1:0]       out_valid_o,
    output logic [T_W-1:0]     out_tile_o
);

    // The phase counter restarts at the first row-0 read of each tile. The
    // next tile's weight reads occupy phases PF_FIRST..PF_LAST, so every PE
    // has switched before its inactive buffer is overwritten; the next
    // tile may issue its first read once the phase has passed PF_LAST.
    localparam int PH_W       = $clog2(3 * N);
    localparam int PH_MAX     = 3 * N - 1;
    localparam int PF_FIRST   = 2 * N - 1;
    localparam int PF_LAST    = 3 * N - 2;
    localparam int DRAIN_LAST = 2 * N - 1;
    localparam int WF         = AW + T_W;
    localparam int AF         = T_W + M_W;
    localparam int RW         = 2 + AW;

    seq_state_e        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d, phase_inc;
    logic [M_W-1:0]    vec_q, vec_d, m_q, m_d;
    logic [T_W-1:0]    tile_q, tile_d, tiles_q, tiles_d;
    sys_mode_e         mode_q, mode_d;

    logic              last_vec, last_tile, next_ready;
    logic              wload, pf_rd;
    logic [PH_W-1:0]   wrow;
    logic [T_W-1:0]    wtile;
    logic [WF-1:0]     waddr_full;
    logic [AF-1:0]     aaddr_full;
    logic              row0_en, row0_sw;
    logic [RW-1:0]     row0_bundle;
    logic [N-1:0][RW-1:0] rtaps;
    logic [N-1:0][0:0]    otaps;

    logic [N-1:0]      accept_q, valid_q, switch_q;
    logic              obase_q;
    logic              sw_seen_q;
    logic [T_W-1:0]    otile_q;

    assign last_vec   = (vec_q == m_q - M_W'(1));
    assign last_tile  = (tile_q == tiles_q - T_W'(1));
    assign next_ready = (phase_q >= PH_W'(PF_LAST));
    assign phase_inc  = (phase_q == PH_W'(PH_MAX)) ? phase_q : phase_q + PH_W'(1);

    // Sequencer state, latched job configuration and tile/vector counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            vec_q   <= '0;
            tile_q  <= '0;
            m_q     <= '0;
            tiles_q <= '0;
            mode_q  <= MODE_Q88;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            vec_q   <= vec_d;
            tile_q  <= tile_d;
            m_q     <= m_d;
            tiles_q <= tiles_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state logic: load tile 0, then alternate streaming and waiting
    // for the prefetched weights until the last tile drains out.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        vec_d   = vec_q;
        tile_d  = tile_q;
        m_d     = m_q;
        tiles_d = tiles_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    m_d     = cfg_m_i;
                    tiles_d = cfg_tiles_i;
                    mode_d  = sys_mode_e'(cfg_mode_i);
                    phase_d = '0;
                    vec_d   = '0;
                    tile_d  = '0;
                    if (cfg_m_i == '0 || cfg_tiles_i == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_LOAD0;
                    end
                end
            end
            ST_LOAD0: begin
                if (phase_q == PH_W'(N - 1)) begin
                    state_d = ST_STREAM;
                    phase_d = '0;
                end else begin
                    phase_d = phase_inc;
                end
            end
            ST_STREAM: begin
                phase_d = phase_inc;
                vec_d   = vec_q + M_W'(1);
                if (last_vec) begin
                    vec_d = '0;
                    if (last_tile) begin
                        state_d = ST_DRAIN;
                        phase_d = '0;
                    end else if (next_ready) begin
                        tile_d  = tile_q + T_W'(1);
                        phase_d = '0;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                phase_d = phase_inc;
                if (next_ready) begin
                    state_d = ST_STREAM;
                    tile_d  = tile_q + T_W'(1);
                    phase_d = '0;
                end
            end
            ST_DRAIN: begin
                if (phase_q == PH_W'(DRAIN_LAST)) begin
                    state_d = ST_FIN;
                end else begin
                    phase_d = phase_inc;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o        = (state_q == ST_LOAD0) || (state_q == ST_STREAM) ||
                           (state_q == ST_WAIT)  || (state_q == ST_DRAIN);
    assign arr_enabled_o = busy_o;
    assign done_o        = (state_q == ST_FIN);
    assign sys_mode_o    = mode_q;

    // Weight reads: tile 0 during LOAD0, later tiles as a prefetch window
    // behind the current stream; rows are fetched bottom row first.
    always_comb begin
        wload = (state_q == ST_LOAD0);
        pf_rd = ((state_q == ST_STREAM) || (state_q == ST_WAIT)) && !last_tile &&
                (phase_q >= PH_W'(PF_FIRST)) && (phase_q <= PH_W'(PF_LAST));
        wrow  = wload ? phase_q : phase_q - PH_W'(PF_FIRST);
        wtile = wload ? '0 : tile_q + T_W'(1);
        waddr_full = WF'(wtile) * WF'(N) + WF'(N - 1) - WF'(wrow);
        wbuf_rd_en_o   = wload || pf_rd;
        wbuf_rd_addr_o = wbuf_rd_en_o ? AW'(waddr_full) : '0;
    end

    // Row-0 activation read with its tile-start marker; lower rows see the
    // same request delayed by their row index.
    always_comb begin
        row0_en     = (state_q == ST_STREAM);
        row0_sw     = row0_en && (vec_q == '0);
        aaddr_full  = AF'(tile_q) * AF'(m_q) + AF'(vec_q);
        row0_bundle = row0_en ? {1'b1, row0_sw, AW'(aaddr_full)} : '0;
    end

    skew_shift #(.W(RW), .N(N)) u_row_skew (
        .clk    (clk),
        .rst    (rst),
        .d_i    (row0_bundle),
        .taps_o (rtaps)
    );

    // Drive each activation bank straight from its skew tap.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            abuf_rd_en_o[r]            = rtaps[r][RW-1];
            abuf_rd_addr_o[r*AW +: AW] = rtaps[r][AW-1:0];
        end
    end

    // Align accept/valid/switch with the buffer data one cycle after the
    // read, and mark when row N-1's psums emerge at the bottom of column 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accept_q <= '0;
            valid_q  <= '0;
            switch_q <= '0;
            obase_q  <= 1'b0;
        end else begin
            accept_q <= {N{wbuf_rd_en_o}};
            for (int r = 0; r < N; r++) begin
                valid_q[r]  <= rtaps[r][RW-1];
                switch_q[r] <= rtaps[r][RW-2];
            end
            obase_q <= valid_q[N-1];
        end
    end

    assign arr_accept_w_o = accept_q;
    assign arr_valid_o    = valid_q;
    assign arr_switch_o   = switch_q;

    skew_shift #(.W(1), .N(N)) u_out_skew (
        .clk    (clk),
        .rst    (rst),
        .d_i    (obase_q),
        .taps_o (otaps)
    );

    // Column c sees the column-0 psum-valid delayed by c cycles.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            out_valid_o[c] = otaps[c][0];
        end
    end

    // Tile tag for column-0 output: each switch reaching the last row marks
    // the next tile's data arriving at the bottom one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_seen_q <= 1'b0;
            otile_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            sw_seen_q <= 1'b0;
            otile_q   <= '0;
        end else if (switch_q[N-1]) begin
            sw_seen_q <= 1'b1;
            otile_q   <= sw_seen_q ? otile_q + T_W'(1) : '0;
        end
    end

    assign out_tile_o = out_valid_o[0] ? otile_q : '0;

endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Self-checking bench: builds an expected per-cycle waveform from the tile
// timing rules for each job and compares every DUT output cycle by cycle.
module tb_systolic_array_sequencer;

    localparam int N    = 4;
    localparam int M_W  = 16;
    localparam int T_W  = 8;
    localparam int AW   = 16;
    localparam int KMAX = 128;

    logic               clk = 1'b0;
    logic               rst;
    logic               start_i;
    logic [1:0]         cfg_mode_i;
    logic [M_W-1:0]     cfg_m_i;
    logic [T_W-1:0]     cfg_tiles_i;
    logic               busy_o, done_o, arr_enabled_o, wbuf_rd_en_o;
    logic [1:0]         sys_mode_o;
    logic [AW-1:0]      wbuf_rd_addr_o;
    logic [N-1:0]       arr_accept_w_o, abuf_rd_en_o, arr_valid_o, arr_switch_o, out_valid_o;
    logic [N*AW-1:0]    abuf_rd_addr_o;
    logic [T_W-1:0]     out_tile_o;

    int total = 0;
    int bad   = 0;

    logic               eWen   [KMAX];
    logic [AW-1:0]      eWaddr [KMAX];
    logic [N-1:0]       eAcc   [KMAX];
    logic [N-1:0]       eAen   [KMAX];
    logic [N*AW-1:0]    eAaddr [KMAX];
    logic [N-1:0]       eVal   [KMAX];
    logic [N-1:0]       eSw    [KMAX];
    logic [N-1:0]       eOv    [KMAX];
    logic [T_W-1:0]     eOtile [KMAX];
    logic               eBusy  [KMAX];
    logic               eDone  [KMAX];
    int                 eLast;

    systolic_array_sequencer #(.N(N), .M_W(M_W), .T_W(T_W), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .cfg_mode_i     (cfg_mode_i),
        .cfg_m_i        (cfg_m_i),
        .cfg_tiles_i    (cfg_tiles_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .sys_mode_o     (sys_mode_o),
        .arr_enabled_o  (arr_enabled_o),
        .wbuf_rd_en_o   (wbuf_rd_en_o),
        .wbuf_rd_addr_o (wbuf_rd_addr_o),
        .arr_accept_w_o (arr_accept_w_o),
        .abuf_rd_en_o   (abuf_rd_en_o),
        .abuf_rd_addr_o (abuf_rd_addr_o),
        .arr_valid_o    (arr_valid_o),
        .arr_switch_o   (arr_switch_o),
        .out_valid_o    (out_valid_o),
        .out_tile_o     (out_tile_o)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input int k, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, got, exp);
        end
    endtask

    // Expected waveform, cycle k counted from the edge that samples start.
    task automatic buildModel(input int m, input int tiles);
        int s, sPrev, rd, d;
        for (int k = 0; k < KMAX; k++) begin
            eWen[k] = 1'b0; eWaddr[k] = '0; eAcc[k] = '0; eAen[k] = '0;
            eAaddr[k] = '0; eVal[k] = '0; eSw[k] = '0; eOv[k] = '0;
            eOtile[k] = '0; eBusy[k] = 1'b0; eDone[k] = 1'b0;
        end
        if (m == 0 || tiles == 0) begin
            eDone[1] = 1'b1;
            eLast = 1;
            return;
        end
        sPrev = 0;
        for (int t = 0; t < tiles; t++) begin
            rd = (t == 0) ? 1 : sPrev + 2 * N - 2;
            for (int k = 0; k < N; k++) begin
                eWen[rd + k]   = 1'b1;
                eWaddr[rd + k] = AW'(t * N + N - 1 - k);
                eAcc[rd + k + 1] = '1;
            end
            s = rd + N + 1;
            if (t > 0 && sPrev + m > s) s = sPrev + m;
            for (int r = 0; r < N; r++) begin
                for (int mm = 0; mm < m; mm++) begin
                    eAen[s + r + mm - 1][r] = 1'b1;
                    eAaddr[s + r + mm - 1][r*AW +: AW] = AW'(t * m + mm);
                    eVal[s + r + mm][r] = 1'b1;
                    eOv[s + N + r + mm][r] = 1'b1;
                    if (r == 0) eOtile[s + N + mm] = T_W'(t);
                end
                eSw[s + r][r] = 1'b1;
            end
            sPrev = s;
        end
        d = sPrev + m + 2 * N - 1;
        for (int k = 1; k < d; k++) eBusy[k] = 1'b1;
        eDone[d] = 1'b1;
        eLast = d;
    endtask

    task automatic checkOutput(input int k, input logic [1:0] mode);
        checkVal("busy", k, busy_o, eBusy[k]);
        checkVal("done", k, done_o, eDone[k]);
        checkVal("arr_enabled", k, arr_enabled_o, eBusy[k]);
        checkVal("sys_mode", k, sys_mode_o, mode);
        checkVal("wbuf_rd_en", k, wbuf_rd_en_o, eWen[k]);
        if (eWen[k]) checkVal("wbuf_rd_addr", k, wbuf_rd_addr_o, eWaddr[k]);
        checkVal("accept_w", k, arr_accept_w_o, eAcc[k]);
        checkVal("abuf_rd_en", k, abuf_rd_en_o, eAen[k]);
        for (int r = 0; r < N; r++) begin
            if (eAen[k][r]) checkVal("abuf_rd_addr", k, abuf_rd_addr_o[r*AW +: AW], eAaddr[k][r*AW +: AW]);
        end
        checkVal("arr_valid", k, arr_valid_o, eVal[k]);
        checkVal("arr_switch", k, arr_switch_o, eSw[k]);
        checkVal("out_valid", k, out_valid_o, eOv[k]);
        if (eOv[k][0]) checkVal("out_tile", k, out_tile_o, eOtile[k]);
    endtask

    task automatic checkZero(input int k);
        checkVal("rst_ctrl", k,
                 {busy_o, done_o, sys_mode_o, arr_enabled_o, wbuf_rd_en_o, wbuf_rd_addr_o,
                  arr_accept_w_o, abuf_rd_en_o, arr_valid_o, arr_switch_o, out_valid_o, out_tile_o},
                 64'd0);
        checkVal("rst_abuf_addr", k, abuf_rd_addr_o, 64'd0);
    endtask

    // One job: start at cycle 0, optional ignored start pulse, optional abort.
    task automatic applyStimulus(input int m, input int tiles, input logic [1:0] mode,
                                 input int pulseAt, input int abortAt);
        buildModel(m, tiles);
        @(negedge clk);
        start_i     = 1'b1;
        cfg_m_i     = M_W'(m);
        cfg_tiles_i = T_W'(tiles);
        cfg_mode_i  = mode;
        @(negedge clk);
        start_i     = 1'b0;
        cfg_m_i     = M_W'($urandom_range(1, 50));
        cfg_tiles_i = T_W'($urandom_range(1, 9));
        cfg_mode_i  = ~mode;
        for (int k = 1; k <= eLast + 2; k++) begin
            checkOutput(k, mode);
            if (k == abortAt) begin
                #1 rst = 1'b1;
                #1 checkZero(k);
                @(negedge clk);
                checkZero(k + 1);
                @(negedge clk);
                checkZero(k + 2);
                rst = 1'b0;
                return;
            end
            start_i = (k == pulseAt);
            if (k == pulseAt) begin
                cfg_m_i     = M_W'($urandom_range(1, 50));
                cfg_tiles_i = T_W'($urandom_range(2, 9));
            end
            @(negedge clk);
        end
        start_i = 1'b0;
    endtask

    initial begin
        int m, tiles;
        logic [1:0] mode;
        rst         = 1'b1;
        start_i     = 1'b0;
        cfg_mode_i  = '0;
        cfg_m_i     = '0;
        cfg_tiles_i = '0;
        repeat (2) @(negedge clk);
        checkZero(0);
        rst = 1'b0;

        $display("[TB] basic single tile");
        applyStimulus(3, 1, 2'b01, -1, -1);
        $display("[TB] two tiles with overlapping prefetch");
        applyStimulus(10, 2, 2'b10, -1, -1);
        $display("[TB] short tiles waiting on prefetch");
        applyStimulus(1, 3, 2'b11, -1, -1);
        $display("[TB] start pulse mid-stream");
        applyStimulus(5, 2, 2'b00, 8, -1);
        $display("[TB] reset mid-stream then rerun");
        applyStimulus(6, 2, 2'b01, -1, 8);
        applyStimulus(3, 1, 2'b10, -1, -1);
        $display("[TB] empty jobs");
        applyStimulus(0, 2, 2'b11, -1, -1);
        applyStimulus(4, 0, 2'b01, -1, -1);

        $display("[TB] random jobs");
        repeat (6) begin
            m     = int'($urandom_range(1, 12));
            tiles = int'($urandom_range(1, 3));
            mode  = 2'($urandom_range(0, 3));
            applyStimulus(m, tiles, mode, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_array_sequencer.md
Name: systolic_array_sequencer

Overview:
Control sequencer for an N×N weight-stationary systolic array of packed-mode PEs. Each PE holds double-buffered weights (active/inactive), passes weights south, and passes inputs, valid and switch east.
Per tile, the block reads N weight rows from the weight buffer and reads M activation vectors from N banked activation buffers. It generates the per-column accept_w, per-row valid/switch with diagonal skew, and the per-column output-valid strobes for psum capture.
Weight loading for tile t+1 overlaps streaming of tile t.

Parameters:
N, 4, array dimension (rows = columns)
M_W, 16, width of vectors-per-tile count
T_W, 8, width of tile count
AW, 16, buffer address width

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin job; sampled only in IDLE
cfg_mode  in  2  PE mode (00 Q8.8, 01 INT16, 10 INT8x2, 11 INT4x4); latched at start
cfg_m  in  M_W  vectors per tile; latched at start
cfg_tiles  in  T_W  tile count; latched at start
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse at job end
sys_mode  out  2  latched cfg_mode, driven to all PEs
arr_enabled  out  1  PE enable, high while busy
wbuf_rd_en  out  1  weight buffer read enable
wbuf_rd_addr  out  AW  weight row address
arr_accept_w  out  N  per-column weight accept (identical bits)
abuf_rd_en  out  N  per-bank activation read enable
abuf_rd_addr  out  N*AW  per-bank address, bank r at [r*AW +: AW]
arr_valid  out  N  per-row west valid into column 0
arr_switch  out  N  per-row west switch into column 0
out_valid  out  N  per-column psum-valid at the bottom of the array
out_tile  out  T_W  tile index of the current out_valid data

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. Reset returns the block to IDLE and zeroes every output, including sys_mode. Reset mid-job abandons the job with no done pulse.
- States: IDLE, LOAD0, STREAM, WAIT, DRAIN, FIN.
- IDLE:
  - start latches cfg_*.
  - cfg_m==0 or cfg_tiles==0 -> FIN (done pulses on the next cycle with no array activity).
  - Otherwise -> LOAD0.
  - start while not in IDLE is ignored.
- Buffer read latency is 1 cycle. arr_accept_w, arr_valid and arr_switch are the read enables delayed by one register so they align with the data.
- Weight load, tile t:
  - N consecutive reads at addr t*N+(N-1-k), k=0..N-1 (bottom row first).
  - arr_accept_w is all-ones for the N aligned cycles. load_end = last such cycle.
- Stream, tile t. Let S = the first cycle arr_switch[0]/arr_valid[0] is high for the tile.
  - Row r: arr_valid[r] is high on cycles S+r .. S+r+M-1.
  - arr_switch[r] is a 1-cycle pulse at S+r.
  - Bank r address = t*M+m for vector m, read at S+r+m-1.
- Tile ordering:
  - Tile 0: S = load_end+1 (start sampled at cycle 0 gives reads on 1..N, accept_w on 2..N+1, S=N+2).
  - Prefetch of tile t+1 starts its aligned accept_w no earlier than S+2N-1, after all PEs have switched.
  - Tile t+1 begins at S' = max(S+M, load_end'+1). STREAM -> WAIT when the stream ends before the prefetch completes.
- Output: out_valid[c] is high on S+N+c .. S+N+c+M-1 for each tile. out_tile is valid with out_valid[0]. Columns staggered by c sample out_tile via a delayed copy.
- DRAIN: after the last tile's final row-0 valid, wait until the last out_valid[N-1] at S+M+2N-2. Then FIN: done=1 for one cycle, busy and arr_enabled drop at the same edge, -> IDLE.
- Counters: vector count 0..M-1 and tile count 0..cfg_tiles-1 have no wrap. Address arithmetic is truncated to AW bits.

Decomposition:
- Shared package tpu_pkg: sys_mode_e enum (MODE_Q88, MODE_INT16, MODE_INT8X2, MODE_INT4X4) and seq_state_e.
- Sub-module skew_shift (N-tap delay line) generates the per-row valid/switch skew and per-column out_valid stagger.

Test Plan:
1. N=4, M=3, tiles=1, start at cycle 0 -> wbuf_rd_en on 1-4 with addr 3,2,1,0; accept_w on 2-5; switch[r] at 6+r; out_valid[0] on 10-12, out_valid[3] on 13-15; done at 16.
2. M=10, tiles=2 -> tile1 accept_w on S+7..S+10; switch[0] of tile1 at S+11; out_tile=1 on the second burst; a single done.
3. M=1, tiles=3 -> WAIT entered each tile; each new S = previous load_end+1; no arr_valid overlaps a later accept_w of the same row's PEs before S+2N-1.
4. start pulsed during STREAM -> ignored; latched cfg unchanged; exactly one done.
5. rst asserted mid-STREAM -> all outputs 0 asynchronously; state IDLE; no done; a new start runs scenario 1 timing exactly.
6. cfg_m=0 -> no reads, arr_enabled never high, done exactly one cycle after start.
